// File: rtl/alu_result_collector.sv
// Collects completed results from wrapper_alu into a small FWFT FIFO drained over valid/ready.
// Optional running XOR of accepted bytes when ALU_COLLECT_CHECKSUM_EN is defined.
module alu_result_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       alu_done,
    output logic [DATA_W-1:0]          res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
`ifdef ALU_COLLECT_CHECKSUM_EN
    output logic [DATA_W-1:0]          checksum,
`endif
    output logic [CNT_W-1:0]           result_total
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic              done_q_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [AW:0]       count_next;
    logic              valid_reg;
    logic              overflow_reg;
    logic [CNT_W-1:0]  total_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign capture = alu_done & ~done_q_reg;
    assign full    = (count_reg == DEPTH_C);
    assign pop     = valid_reg & res_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_reg] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            total_reg    <= '0;
        end else begin
            done_q_reg <= alu_done;
            count_reg  <= count_next;
            valid_reg  <= (count_next != '0);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                total_reg  <= total_reg + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Remembers the last head byte so res_data stays defined while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (valid_reg) begin
            hold_reg <= mem[rd_ptr_reg];
        end
    end

`ifdef ALU_COLLECT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (push) begin
            checksum_reg <= checksum_reg ^ alu_data;
        end
    end

    assign checksum = checksum_reg;
`endif

    assign res_data     = valid_reg ? mem[rd_ptr_reg] : hold_reg;
    assign res_valid    = valid_reg;
    assign fifo_count   = count_reg;
    assign overflow     = overflow_reg;
    assign result_total = total_reg;

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_done;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  result_total;
`ifdef ALU_COLLECT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    alu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_data     (alu_data),
        .alu_done     (alu_done),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
`ifdef ALU_COLLECT_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .result_total (result_total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [7:0] m_q[$];
    int         m_total;
    logic       m_ovf;
    logic       m_prev_done;
    logic [7:0] m_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(res_valid), 32'(m_q.size() != 0));
        check("count", 32'(fifo_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("total", 32'(result_total), 32'(m_total));
        if (m_q.size() != 0) check("data", 32'(res_data), 32'(m_q[0]));
`ifdef ALU_COLLECT_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(m_chk));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input logic done, input logic [7:0] data, input logic ready, input logic do_rst);
        logic       cap;
        logic [7:0] popped;
        alu_done  = done;
        alu_data  = data;
        res_ready = ready;
        rst       = do_rst;
        @(posedge clk);
        if (do_rst) begin
            m_q.delete();
            m_total     = 0;
            m_ovf       = 1'b0;
            m_prev_done = 1'b0;
            m_chk       = 8'h00;
            $display("reset");
        end else begin
            cap = done && !m_prev_done;
            if (m_q.size() != 0 && ready) begin
                popped = m_q.pop_front();
                $display("pop  0x%02h", popped);
            end
            if (cap) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(data);
                    m_total = (m_total + 1) % (1 << CNT_W);
                    m_chk   = m_chk ^ data;
                    $display("push 0x%02h", data);
                end else begin
                    m_ovf = 1'b1;
                    $display("drop 0x%02h", data);
                end
            end
            m_prev_done = done;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input logic [7:0] data);
        cycle(1'b1, data, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_b;
        int         ready_bias;
        rst       = 1'b1;
        alu_done  = 1'b0;
        alu_data  = '0;
        res_ready = 1'b0;
        m_q.delete();
        m_total = 0; m_ovf = 0; m_prev_done = 0; m_chk = 0;
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("reset_data", 32'(res_data), 32'h0);
        check("reset_valid", 32'(res_valid), 32'h0);

        // Single result, held, then popped
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check("single_valid", 32'(res_valid), 32'h1);
        check("single_data", 32'(res_data), 32'h3C);
        check("single_count", 32'(fifo_count), 32'h1);
        check("single_total", 32'(result_total), 32'h1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("hold_data", 32'(res_data), 32'h3C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_count", 32'(fifo_count), 32'h0);
        check("pop_valid", 32'(res_valid), 32'h0);

        // Level held high gives one capture
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("level_count", 32'(fifo_count), 32'h1);
        check("level_total", 32'(result_total), 32'h1);

        // Fill and overflow
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) pulse(8'(i));
        check("fill_count", 32'(fifo_count), 32'h8);
        check("fill_ovf", 32'(overflow), 32'h1);
        check("fill_total", 32'(result_total), 32'h8);
        for (int i = 1; i <= 8; i++) begin
            check("fill_drain", 32'(res_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(res_valid), 32'h0);
        check("drain_ovf", 32'(overflow), 32'h1);

        // Full with simultaneous pop
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) pulse(8'(i));
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        check("fullpop_ovf", 32'(overflow), 32'h0);
        check("fullpop_count", 32'(fifo_count), 32'h8);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            exp_b = (i == 9) ? 8'hAA : 8'(i);
            check("fullpop_drain", 32'(res_data), 32'(exp_b));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Reset mid-stream with a concurrent capture
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(8'(8'h40 + i));
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_total", 32'(result_total), 32'h0);
        check("rst_data", 32'(res_data), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef ALU_COLLECT_CHECKSUM_EN
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        pulse(8'h0F);
        pulse(8'hF0);
        pulse(8'h55);
        check("chk_value", 32'(checksum), 32'hAA);
        for (int i = 0; i < 5; i++) pulse(8'h00);
        pulse(8'h33);
        check("chk_drop_ovf", 32'(overflow), 32'h1);
        check("chk_after_drop", 32'(checksum), 32'hAA);
`endif

        // Randomized traffic with varying consumer pressure
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 0) ready_bias = $urandom_range(0, 3);
            cycle(1'b1 & ($urandom_range(0, 2) != 0),
                  8'($urandom),
                  ($urandom_range(0, 3) < ready_bias),
                  ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of `wrapper_alu`. It detects each completed result from the ALU wrapper (rising edge of `output_done`) and captures the result byte on `data_out`. Captured bytes are buffered in a small first-word-fall-through FIFO and drained by the consumer over a valid/ready handshake. It also keeps an accepted-result counter and a sticky overflow flag for results lost while the FIFO was full.

## Interface
Parameters:
- `DATA_W`, 8: width of the result byte; matches `wrapper_alu` `data_out`.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the accepted-result counter.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_data`  in  DATA_W  result byte; connects to `wrapper_alu.data_out`.
- `alu_done`  in  1  result-complete indicator; connects to `wrapper_alu.output_done`.
- `res_data`  out  DATA_W  head-of-FIFO result byte.
- `res_valid`  out  1  `res_data` holds a valid entry.
- `res_ready`  in  1  consumer accepts the head entry.
- `fifo_count`  out  $clog2(DEPTH)+1  number of entries currently held.
- `overflow`  out  1  sticky: at least one result was dropped.
- `result_total`  out  CNT_W  number of results accepted into the FIFO.

## Operation
- **Edge detect.** `done_q` registers `alu_done` every cycle. A capture event occurs in any cycle where `alu_done` is 1 and `done_q` is 0. `alu_data` is sampled in that same cycle.
- **Push.**
  - On a capture event with the FIFO not full, write `alu_data` to `wr_ptr`, increment `wr_ptr` modulo DEPTH, and increment `result_total`.
  - `result_total` wraps from 2^CNT_W−1 to 0.
- **Pop.** When `res_valid` and `res_ready` are both 1, increment `rd_ptr` modulo DEPTH.
- **Count.** `fifo_count` rises by 1 on push only, falls by 1 on pop only, and is unchanged when push and pop occur together.
- **Full with simultaneous pop.** The pop frees a slot in the same edge, so the push is accepted. No overflow is raised.
- **Full without pop.** The capture event is dropped: `overflow` is set to 1, and `result_total` and the FIFO contents are unchanged.
- **Overflow clear.** `overflow` clears only on `rst`.
- **Empty.** `res_valid` is 0. `res_ready` is ignored. `res_data` is don't-care but holds its last value; it does not go X.
- **Holding.** While `res_valid` is 1 and `res_ready` is 0, `res_data` and `res_valid` are held stable.
- **Reset mid-operation.** All entries are discarded and pointers return to 0. A capture event in the reset cycle is ignored.

## Timing
- **Reset values:**
  - `res_valid` = 0, `res_data` = 0, `fifo_count` = 0
  - `overflow` = 0, `result_total` = 0
  - `done_q` = 0, pointers = 0
- **Latency.** A capture event at edge N makes `res_valid` = 1 with the captured byte on `res_data` after edge N (visible in cycle N+1). This holds even when the FIFO was empty.
- **Throughput.** One push and one pop per cycle. Back-to-back capture events need `alu_done` to return low for at least one cycle between them.
- **Held level.** An `alu_done` level held high for many cycles produces exactly one capture.
- **Output registering.** `res_valid`, `fifo_count`, `overflow` and `result_total` are registered. `res_data` is read combinationally from the registered `rd_ptr` into the storage array, so it involves no input-to-output combinational path.

## Configuration
- **Macro:** `ALU_COLLECT_CHECKSUM_EN`.
- **Defined:**
  - Adds output port `checksum` (DATA_W bits), the running XOR of every byte accepted into the FIFO.
  - Reset value 0.
  - Updated on the same edge as the push; dropped bytes are excluded.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Single result.** Pulse `alu_done` for 1 cycle with `alu_data` = 0x3C and `res_ready` = 0. Require, next cycle: `res_valid` = 1, `res_data` = 0x3C, `fifo_count` = 1, `result_total` = 1. Holds stable for 10 cycles. Raising `res_ready` for 1 cycle gives `fifo_count` = 0 and `res_valid` = 0.
- **Level hold.** Hold `alu_done` high for 20 cycles with `alu_data` = 0x11. Require exactly one entry and `result_total` = 1.
- **Fill and overflow.** With `res_ready` = 0, issue 9 capture events with bytes 0x01–0x09 (DEPTH = 8). Require `fifo_count` = 8, `overflow` = 1, `result_total` = 8. Draining yields 0x01–0x08 in order; `overflow` stays 1.
- **Full with simultaneous pop.** Fill with 0x01–0x08. Then capture 0xAA in the same cycle as a pop. Require `overflow` = 0 and `fifo_count` = 8. The drain order is 0x02–0x08, then 0xAA.
- **Reset mid-stream.** Load 3 entries, then assert `rst` for 1 cycle together with a capture event. Require all outputs at their reset values next cycle, and no entry from the concurrent capture.
- **Checksum (macro defined).** Capture 0x0F, 0xF0, 0x55. Require `checksum` = 0xAA. After a further dropped overflow byte, `checksum` is unchanged.
